mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 bit-select mux between four requesters. Each requester raises a request line. The block grants exactly one requester at a time, drives the mux select for that requester, and forwards that requester's data bit to the LED output. It sits in front of the select/data mux and owns its select input.

## Interface

**Parameters**
- `HOLD_CYCLES`, default 8: maximum grant length in cycles. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 1..255.

**Ports**
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous reset, active-high.
- `req`  input  4  request lines; `req[i]` high means requester i wants the mux.
- `c`  input  4  data bits; `c[i]` belongs to requester i.
- `grant`  output  4  one-hot grant, registered; all zero when idle.
- `select`  output  2  registered mux select, equal to the index of the granted requester.
- `valid`  output  1  registered; high while a grant is active.
- `LED`  output  1  combinational, equal to `c[select] & valid`.
- `timeout`  output  1  registered one-cycle pulse when a grant is revoked by the hold limit.

## Operation

**State machine**
- Two states, IDLE and GRANT.
- Internal state: a 2-bit round-robin pointer `ptr` and a hold counter `cnt` that is 8 bits wide.

**IDLE**
- If `req` is zero, stay in IDLE.
- Otherwise, pick the first i with `req[i]=1`, searching in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On the next edge: `grant` = one-hot(i), `select` = i, `valid` = 1, `cnt` = 0, and the state becomes GRANT.

**GRANT**
- If `req[select]` = 0, release the grant.
- Release means that on the next edge: `grant` = 0, `valid` = 0, `ptr` = select+1 (mod 4), and the state becomes IDLE.
- `select` holds its last value after release.
- Otherwise `cnt` increments by 1 each cycle, which only matters when `ARB_TIMEOUT_EN` is defined (see Configuration).

**Rules that hold in both states**
- Requests from non-granted requesters are ignored while in GRANT; they are only sampled in IDLE.
- At most one `grant` bit is high at any time.
- `valid` equals `|grant` on every cycle.

## Timing

- **Reset values:** `grant` = 0, `select` = 0, `valid` = 0, `timeout` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
  - Reset is asynchronous; outputs clear immediately, without waiting for a clock edge.
  - Because `valid` clears, `LED` reads 0 during reset.
- **Request to grant:** 1 cycle. A `req` seen in IDLE at edge N gives `grant` valid after edge N.
- **Drop to release:** 1 cycle. `req[select]` low at edge N gives `grant` = 0 after edge N.
- **Dead cycle:** every release is followed by at least one IDLE cycle. Back-to-back requesters therefore see a 1-cycle gap with `valid` = 0.
- **Simultaneous requests:** resolved purely by `ptr`. After reset with `req` = 4'b1111, the grant order is 0, 1, 2, 3, 0, …
- **Same requester re-requesting:** a requester that drops and immediately re-raises `req` gets the grant again only if no other requester sits earlier in the rotation.
- **Counter wrap:** `cnt` saturates at 255; it never wraps.
- **Reset mid-grant:** the grant is dropped asynchronously and `ptr` returns to 0.
- **LED path:** `LED` follows changes on `c` combinationally, with zero latency, while `valid` is high.

## Configuration

- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - In GRANT, when `cnt` = `HOLD_CYCLES`-1 and `req[select]` is still 1, the grant is released exactly as for a request drop (same cycle rules, same `ptr` update).
  - The same edge sets `timeout` = 1 for one cycle.
  - A granted requester therefore holds the mux for at most `HOLD_CYCLES` cycles.
  - If the requester drops `req` on the same cycle the limit is reached, it is a normal release with `timeout` = 0.
- **Not defined:**
  - The grant is held until `req[select]` drops.
  - `timeout` is tied to 0.
  - `cnt` logic and `HOLD_CYCLES` are unused.

## Test plan

- **Reset value check:** assert `reset` with `req` = 4'b1111 → `grant` = 0, `valid` = 0, `LED` = 0. Deassert → `grant` = 4'b0001 one cycle later.
- **Data forwarding:** `req` = 4'b0100, `c` = 4'b0100 → after 1 cycle `select` = 2, `LED` = 1. Toggle `c[2]` to 0 → `LED` = 0 in the same cycle. Toggle `c[1]` → `LED` unchanged.
- **Rotation fairness:** hold `req` = 4'b1111 and release each grant after 3 cycles by dropping that `req` bit for one cycle → grant order 0, 1, 2, 3, 0, with one `valid` = 0 cycle between grants.
- **Pointer skip:** after requester 1 is released, raise `req` = 4'b1001 → requester 3 is granted, not requester 0.
- **Timeout, macro defined, `HOLD_CYCLES` = 4:** `req` = 4'b0011 held constant → requester 0 granted for exactly 4 cycles, `timeout` pulses once, 1 idle cycle follows, then requester 1 is granted. Without the macro, requester 0 keeps the grant indefinitely and `timeout` stays 0.
- **Reset mid-grant:** reset asynchronously while requester 2 holds the grant → `grant` = 0 before the next clock edge. After release with `req` = 4'b0101, requester 0 is granted (`ptr` = 0).

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bus between the round-robin arbiter and its requesters/LED mux.
// slave: the arbiter side; master: the requester/observer side.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] c;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       LED;
  logic       timeout;

  modport slave (
    input  req, c,
    output grant, select, valid, LED, timeout
  );

  modport master (
    output req, c,
    input  grant, select, valid, LED, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 bit mux; forwards the
// granted requester's data bit to LED.
// Optional grant hold limit enabled by defining ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input logic             clk,
  input logic             reset,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_n;
  logic [1:0] ptr_q, ptr_n;
  logic [7:0] cnt_q, cnt_n;
  logic [3:0] grant_q, grant_n;
  logic [1:0] select_q, select_n;
  logic       valid_q, valid_n;
  logic       timeout_q, timeout_n;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       drop;
  logic       at_limit;

`ifdef ARB_TIMEOUT_EN
  // Hold limit reached while the owner still requests.
  always_comb at_limit = (cnt_q == HOLD_LAST) && bus.req[select_q];
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_LAST;
  always_comb at_limit = 1'b0;
`endif

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    grant_n   = grant_q;
    select_n  = select_q;
    valid_n   = valid_q;
    timeout_n = 1'b0;
    drop      = !bus.req[select_q];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_n  = 4'b0001 << pick;
          select_n = pick;
          valid_n  = 1'b1;
          cnt_n    = '0;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        if (drop || at_limit) begin
          grant_n   = '0;
          valid_n   = 1'b0;
          ptr_n     = select_q + 2'd1;
          timeout_n = at_limit;
          state_n   = IDLE;
        end else begin
          cnt_n = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      select_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      grant_q   <= grant_n;
      select_q  <= select_n;
      valid_q   <= valid_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.select  = select_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.LED     = bus.c[select_q] & valid_q;

endmodule
